// File: rtl/sha256_blk_realign.sv
// SHA-256 block realigner: turns per-cycle chunk descriptors plus the memory
// word returned one cycle later into big-endian 32-bit message words,
// exactly 16 per block, tagged with thread, word index and block op.
// Optional framing checks (err output) are compiled in with
// `define REALIGN_FRAME_CHECK_EN; without it err is tied to 0.

`ifndef MSB
`define MSB(x) (((x) < 2) ? 0 : $clog2((x) + 1) - 1)
`endif
`ifndef PROCB_TOTAL_MSB
`define PROCB_TOTAL_MSB 31
`endif
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 1
`endif

module sha256_blk_realign #(
  parameter int N_THREADS     = -1,
  parameter int N_THREADS_MSB = `MSB(N_THREADS - 1),
  parameter int TOTAL_MSB     = `PROCB_TOTAL_MSB
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   mem_rd_en,
  input  logic [N_THREADS_MSB:0] thread_num,
  input  logic [2:0]             len,
  input  logic [1:0]             off,
  input  logic                   add0x80pad,
  input  logic                   add0pad,
  input  logic                   add_total,
  input  logic [TOTAL_MSB:0]     total,
  input  logic                   blk_end,
  input  logic [`BLK_OP_MSB:0]   blk_op,
  input  logic [31:0]            mem_dout,
  output logic                   out_wr_en,
  output logic [31:0]            out_data,
  output logic [N_THREADS_MSB:0] out_thread_num,
  output logic [3:0]             out_word_idx,
  output logic                   out_blk_end,
  output logic [`BLK_OP_MSB:0]   out_blk_op,
  output logic                   err
);

  // Chunk kind decode: exactly one source flag makes a valid chunk.
  logic [3:0] kind;
  logic       any_kind;
  logic       one_kind;

  assign kind     = {mem_rd_en, add0x80pad, add0pad, add_total};
  assign any_kind = |kind;
  assign one_kind = any_kind && ((kind & (kind - 4'd1)) == 4'd0);

  // Stage-1 registers, aligned with mem_dout.
  logic                   s1_vld;
  logic                   s1_mem;
  logic                   s1_pad80;
  logic                   s1_is_total;
  logic                   s1_blk_end;
  logic [2:0]             s1_len;
  logic [1:0]             s1_off;
  logic [N_THREADS_MSB:0] s1_thread;
  logic [TOTAL_MSB:0]     s1_total_bytes;
  logic [`BLK_OP_MSB:0]   s1_blk_op;

  // Packing state: carry bytes left-aligned, zero beyond cnt_q.
  logic [23:0] carry_q;
  logic [1:0]  cnt_q;
  logic [3:0]  idx_q;

  // Capture the chunk descriptor so it lines up with the returned memory word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld         <= 1'b0;
      s1_mem         <= 1'b0;
      s1_pad80       <= 1'b0;
      s1_is_total    <= 1'b0;
      s1_blk_end     <= 1'b0;
      s1_len         <= '0;
      s1_off         <= '0;
      s1_thread      <= '0;
      s1_total_bytes <= '0;
      s1_blk_op      <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      s1_vld         <= one_kind;
      s1_mem         <= mem_rd_en;
      s1_pad80       <= add0x80pad;
      s1_is_total    <= add_total;
      s1_blk_end     <= blk_end;
      s1_len         <= len;
      s1_off         <= off;
      s1_thread      <= thread_num;
      s1_total_bytes <= total;
      s1_blk_op      <= blk_op;
    end
  end

  logic [2:0]  eff_len;
  logic [31:0] len_mask;
  logic [31:0] mem_sh;
  logic [31:0] mem_be;
  logic [31:0] tot_w;
  logic [31:0] chunk_w;
  logic [55:0] merged;
  logic [3:0]  new_cnt;
  logic        emit;

  // Build the chunk's bytes left-aligned and merge them behind the carry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    chunk_w  = 32'h0;
    eff_len  = s1_is_total ? 3'd4 : ((s1_len > 3'd4) ? 3'd4 : s1_len);
    len_mask = ~(32'hFFFF_FFFF >> {eff_len, 3'b000});
    mem_sh   = mem_dout >> {s1_off, 3'b000};
    mem_be   = {mem_sh[7:0], mem_sh[15:8], mem_sh[23:16], mem_sh[31:24]};
    tot_w    = 32'({s1_total_bytes, 3'b000});
    if (s1_mem)           chunk_w = mem_be & len_mask;
    else if (s1_pad80)    chunk_w = 32'h8000_0000 & len_mask;
    else if (s1_is_total) chunk_w = tot_w;
    merged  = {carry_q, 32'h0} | ({chunk_w, 24'h0} >> {cnt_q, 3'b000});
    new_cnt = {2'b00, cnt_q} + {1'b0, eff_len};
    emit    = s1_vld && (new_cnt >= 4'd4);
  end

  // Emit completed words and advance carry/count/index; blk_end restarts the block.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_wr_en      <= 1'b0;
      out_data       <= '0;
      out_thread_num <= '0;
      out_word_idx   <= '0;
      out_blk_end    <= 1'b0;
      out_blk_op     <= '0;
      carry_q        <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
    end else begin
      out_wr_en      <= emit;
      out_data       <= emit ? merged[55:24] : 32'h0;
      out_thread_num <= emit ? s1_thread : '0;
      out_word_idx   <= emit ? idx_q : 4'd0;
      out_blk_end    <= emit && (idx_q == 4'd15);
      out_blk_op     <= (emit && (idx_q == 4'd15)) ? s1_blk_op : '0;
      if (s1_vld) begin
        if (s1_blk_end) begin
          carry_q <= '0;
          cnt_q   <= '0;
          idx_q   <= '0;
        end else if (emit) begin
          carry_q <= merged[23:0];
          cnt_q   <= 2'(new_cnt - 4'd4);
          idx_q   <= idx_q + 4'd1;
        end else begin
          carry_q <= merged[55:32];
          cnt_q   <= new_cnt[1:0];
        end
      end
    end
  end

`ifdef REALIGN_FRAME_CHECK_EN
  logic                   s1_multi;
  logic                   s1_range;
  logic [N_THREADS_MSB:0] cur_thread_q;
  logic [3:0]             cnt_left;
  logic [3:0]             idx_after;
  logic                   frame_err;
  logic                   err_q;

  // Register the input-side framing faults alongside the chunk.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_multi <= 1'b0;
      s1_range <= 1'b0;
    end else begin
      s1_multi <= any_kind && !one_kind;
      s1_range <= mem_rd_en && (({2'b00, off} + {1'b0, len}) > 4'd4);
    end
  end

  // Collect every framing violation seen on the current chunk.
  always_comb begin
    cnt_left  = emit ? (new_cnt - 4'd4) : new_cnt;
    idx_after = emit ? (idx_q + 4'd1) : idx_q;
    frame_err = s1_multi
              | (s1_vld & s1_range)
              | (s1_vld & s1_blk_end & ((cnt_left != 4'd0) | (idx_after != 4'd0)))
              | (emit & (idx_q == 4'd15) & ~s1_blk_end)
              | (s1_vld & (s1_thread != cur_thread_q) & ((cnt_q != 2'd0) | (idx_q != 4'd0)));
  end

  // Track the active thread and hold err until reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_thread_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (s1_vld) cur_thread_q <= s1_thread;
      if (frame_err) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/sha256_blk_realign.md
Name: sha256_blk_realign

Overview:
- Consumes per-cycle chunk descriptors (read enable, offset, length, pad and total flags) produced by the block-creation stage, plus the 32-bit word that the procb memory returns one cycle after each read.
- Extracts 0–4 bytes per chunk, or generates 0x80/zero pad bytes or the bit-length word, and packs the bytes into big-endian 32-bit message words.
- Emits exactly 16 words per 64-byte block to the SHA-256 core input, tagged with thread number, word index and block op.

Parameters:
- N_THREADS, -1, number of threads; must be overridden.
- N_THREADS_MSB, `MSB(N_THREADS-1), MSB of the thread number.
- TOTAL_MSB, `PROCB_TOTAL_MSB, MSB of the byte total.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- mem_rd_en  in  1  chunk read from memory this cycle.
- thread_num  in  N_THREADS_MSB+1  thread of the chunk.
- len  in  3  bytes in chunk, 0..4.
- off  in  2  byte offset within the memory word.
- add0x80pad  in  1  chunk is padding whose first byte is 0x80.
- add0pad  in  1  chunk is zero padding.
- add_total  in  1  chunk is the block-length word.
- total  in  TOTAL_MSB+1  message length in bytes.
- blk_end  in  1  last chunk of the block.
- blk_op  in  `BLK_OP_MSB+1  block op, latched at blk_end.
- mem_dout  in  32  memory word, valid 1 cycle after mem_rd_en.
- out_wr_en  out  1  out_data valid.
- out_data  out  32  message word, first byte in [31:24].
- out_thread_num  out  N_THREADS_MSB+1  thread of the word.
- out_word_idx  out  4  word index 0..15.
- out_blk_end  out  1  asserted with word 15.
- out_blk_op  out  `BLK_OP_MSB+1  op of the block, valid with out_blk_end.
- err  out  1  sticky framing error.

Behaviour:
- Reset (RST_N=0, asynchronous): all outputs 0; internal state cleared.
  - Internal state: byte count, carry register, word index, stage-1 registers.
  - A chunk in flight is discarded. No output until a new chunk arrives after RST_N rises.
- Chunk valid: mem_rd_en | add0x80pad | add0pad | add_total.
  - With add_total, len is 4.
  - If more than one of the four chunk-valid inputs is set, the chunk is treated as invalid and err sets (when the check is compiled in).
- Stage 1 (cycle t+1): control inputs registered at t, aligned with mem_dout.
- Source bytes:
  - Memory byte i = mem_dout[8i+7:8i]. Chunk byte k = memory byte off+k, k < len.
  - off+len > 4 is never legal; if it occurs, err sets.
  - add0x80pad: byte0 = 0x80, remaining bytes 0x00.
  - add0pad: all bytes 0x00.
  - add_total: word = {total, 3'b000} truncated to 32 bits; this is the length in bits.
- Packing (stage 2, registered output at t+2; latency 2 from chunk to out_data):
  - Carry register holds cnt bytes, cnt 0..3. New count = cnt + len, 0..7.
  - If new count >= 4: emit carry bytes followed by chunk bytes, first byte at [31:24]; keep the remaining new count - 4 bytes as carry.
  - Otherwise: append the chunk bytes to the carry; no output.
  - len=0 chunks are legal: no bytes, no output, but blk_end still applies.
- Word index: increments on each out_wr_en; wraps 15 -> 0.
- Block end: blk_end is applied after the chunk's bytes are packed.
  - Required final state: word index wrapped to 0, carry cnt 0, i.e. exactly 16 words emitted and no leftover byte.
  - out_blk_end=1 and out_blk_op=blk_op in the cycle word 15 is output; both 0 in other cycles.
  - Violations set err: a leftover carry byte, a word count other than 16, or word 15 emitted without blk_end.
  - On a violation the count and index are forced to 0 so the next block starts clean.
- Thread: out_thread_num = thread_num of the chunk that completes the word.
  - A thread change with cnt != 0 or index != 0 sets err.
- Blk_end and word 15 completing on the same chunk is the normal case and is not an error.
- err stays 1 until reset.

Optional Feature:
- REALIGN_FRAME_CHECK_EN
  - Defined: all err conditions above are implemented.
  - Undefined: err is tied to 0; the check logic is removed; index/count clearing at blk_end is unconditional.

Test Plan:
- Aligned read: 16 chunks off=0 len=4, mem_dout=32'h04030201, blk_end on the 16th -> 16 words 32'h01020304, idx 0..15, out_blk_end with idx 15, err=0.
- Unaligned: chunks (off=3,len=1),(off=0,len=4)×15,(off=0,len=3), mem_dout=32'hDDCCBBAA -> first word 32'hDDAABBCC, 16 words, cnt 0 at blk_end.
- Padding/total: 5 bytes of data, add0x80pad len=3, zero pads, add0pad len=4, add_total with total=5 -> word1 = 32'hxx800000 (xx = data byte 5), word15 = 32'h00000028.
- Len-0 chunk: a len=0 chunk mid-block -> no extra output, word index unchanged.
- Short block: blk_end after 15 words -> err=1 (compiled in); next block's idx starts at 0.
- Reset mid-block: RST_N low after word 7 -> all outputs 0 immediately; the next block starts at idx 0 with no stale carry bytes.
